// File: rtl/triple_vote_sampler_pkg.sv
// Shared types and constants for the triple-sample majority-vote front end.
package triple_vote_sampler_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam int OSR_DEFAULT = 16;

  typedef struct packed {
    int lo;
    int mid;
    int hi;
  } sample_phases_t;

  // Three consecutive phases straddling the middle of the bit period.
  function automatic sample_phases_t sample_phases(input int osr);
    sample_phases_t p;
    p.lo  = osr / 2 - 1;
    p.mid = osr / 2;
    p.hi  = osr / 2 + 1;
    return p;
  endfunction

endpackage

// File: rtl/triple_vote_sampler_maj3.sv
// Three-input majority gate used to vote the mid-bit samples.
module triple_vote_sampler_maj3 (
  input  logic a,
  input  logic b,
  input  logic c,
  output logic y
);

  assign y = (a & b) | (a & c) | (b & c);

endmodule

// File: rtl/triple_vote_sampler.sv
// Oversampling front end: votes three mid-bit samples per bit period and
// presents the result through a single-entry valid/ready output register.
module triple_vote_sampler
  import triple_vote_sampler_pkg::*;
#(
  parameter int OSR   = OSR_DEFAULT,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             din,
  output logic             bit_out,
  output logic             bit_valid,
  input  logic             bit_ready,
  output logic             disagree,
  output logic [CNT_W-1:0] dis_cnt,
  output logic             overrun,
  input  logic             ovr_clr
);

  localparam int             PW      = $clog2(OSR);
  localparam sample_phases_t SP      = sample_phases(OSR);
  localparam logic [PW-1:0]  PH_L    = PW'(SP.lo);
  localparam logic [PW-1:0]  PH_M    = PW'(SP.mid);
  localparam logic [PW-1:0]  PH_H    = PW'(SP.hi);
  localparam logic [PW-1:0]  PH_LAST = PW'(OSR - 1);
  localparam logic [PW-1:0]  PH_ONE  = PW'(1);
  localparam logic [PW-1:0]  PH_ZERO = {PW{1'b0}};
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_t          state, state_next;
  logic [PW-1:0]   phase, phase_next;
  logic            s0, s0_next;
  logic            s1, s1_next;
  logic            vote;
  logic            uni;
  logic            vote_edge;
  logic            ovr_set;
  logic            bit_out_next;
  logic            bit_valid_next;
  logic            disagree_next;
  logic [CNT_W-1:0] dis_cnt_next;
  logic            overrun_next;

  triple_vote_sampler_maj3 u_maj3 (
    .a (s0),
    .b (s1),
    .c (din),
    .y (vote)
  );

  assign uni       = (s0 == s1) && (s1 == din);
  assign vote_edge = (state == RUN) && en && (phase == PH_H);

  // State, phase and sample registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      phase <= PH_ZERO;
      s0    <= 1'b0;
      s1    <= 1'b0;
    end else begin
      state <= state_next;
      phase <= phase_next;
      s0    <= s0_next;
      s1    <= s1_next;
    end
  end

  // Next-state: dropping en anywhere in RUN abandons the partial period.
  always_comb begin
    state_next = state;
    phase_next = phase;
    s0_next    = s0;
    s1_next    = s1;
    case (state)
      IDLE: begin
        phase_next = PH_ZERO;
        s0_next    = 1'b0;
        s1_next    = 1'b0;
        if (en) begin
          state_next = RUN;
        end else begin
          state_next = IDLE;
        end
      end
      RUN: begin
        if (en) begin
          state_next = RUN;
          if (phase == PH_LAST) begin
            phase_next = PH_ZERO;
          end else begin
            phase_next = phase + PH_ONE;
          end
          if (phase == PH_L) begin
            s0_next = din;
          end else begin
            s0_next = s0;
          end
          if (phase == PH_M) begin
            s1_next = din;
          end else begin
            s1_next = s1;
          end
        end else begin
          state_next = IDLE;
          phase_next = PH_ZERO;
          s0_next    = 1'b0;
          s1_next    = 1'b0;
        end
      end
      default: begin
        state_next = IDLE;
        phase_next = PH_ZERO;
        s0_next    = 1'b0;
        s1_next    = 1'b0;
      end
    endcase
  end

  // Output-register update: a load may coincide with consumption of the held bit.
  always_comb begin
    bit_out_next   = bit_out;
    bit_valid_next = bit_valid;
    disagree_next  = disagree;
    dis_cnt_next   = dis_cnt;
    ovr_set        = 1'b0;
    if (vote_edge) begin
      if (!bit_valid || bit_ready) begin
        bit_out_next   = vote;
        bit_valid_next = 1'b1;
        disagree_next  = ~uni;
      end else begin
        ovr_set = 1'b1;
      end
      if (!uni && (dis_cnt != CNT_MAX)) begin
        dis_cnt_next = dis_cnt + CNT_ONE;
      end else begin
        dis_cnt_next = dis_cnt;
      end
    end else if (bit_valid && bit_ready) begin
      bit_valid_next = 1'b0;
    end else begin
      bit_valid_next = bit_valid;
    end
    if (ovr_set) begin
      overrun_next = 1'b1;
    end else if (ovr_clr) begin
      overrun_next = 1'b0;
    end else begin
      overrun_next = overrun;
    end
  end

  // Registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      bit_out   <= 1'b0;
      bit_valid <= 1'b0;
      disagree  <= 1'b0;
      dis_cnt   <= {CNT_W{1'b0}};
      overrun   <= 1'b0;
    end else begin
      bit_out   <= bit_out_next;
      bit_valid <= bit_valid_next;
      disagree  <= disagree_next;
      dis_cnt   <= dis_cnt_next;
      overrun   <= overrun_next;
    end
  end

endmodule

// File: doc/triple_vote_sampler.md
# triple_vote_sampler

Oversampling front end that produces the three samples a 3-input majority stage consumes. Each bit period it takes three consecutive mid-bit samples of a synchronized serial input and majority-votes them into one clean bit. The bit is presented downstream through a single-entry valid/ready output register. The block also reports sample disagreement and sticky overrun for link-quality monitoring.

## Interface
- OSR, 16, clock cycles per bit period; even, ≥ 4
- CNT_W, 8, width of the saturating disagreement counter
- clk  in  1  rising-edge clock; the only clock
- rst  in  1  synchronous, active-high reset
- en  in  1  sampling enable; low forces IDLE
- din  in  1  serial data, already synchronized to clk
- bit_out  out  1  voted bit; stable while bit_valid is high
- bit_valid  out  1  bit_out holds an unconsumed bit
- bit_ready  in  1  downstream accepts bit_out on an edge where both valid and ready are high
- disagree  out  1  the three samples behind bit_out were not unanimous
- dis_cnt  out  CNT_W  count of non-unanimous votes; saturates at all-ones
- overrun  out  1  sticky: a voted bit was dropped because the output register was full
- ovr_clr  in  1  clears overrun

## Operation
- FSM states:
  - IDLE: phase = 0 and sample registers s0/s1 = 0.
  - RUN: phase counts 0..OSR-1 and wraps to 0.
- Transitions:
  - IDLE→RUN on an edge with en=1; the first RUN cycle has phase 0.
  - RUN→IDLE on any edge with en=0. Partial samples are discarded. The output register, dis_cnt and overrun are untouched.
- Sample points: L = OSR/2-1, M = OSR/2, H = OSR/2+1.
  - s0 ← din at the edge where phase = L.
  - s1 ← din at the edge where phase = M.
  - At the edge where phase = H: vote = maj(s0, s1, din), and uni = (s0 = s1 = din).
- Vote load, at the H edge:
  - If the output register is empty, or is being consumed on the same edge: bit_out ← vote, bit_valid ← 1, disagree ← ~uni.
  - Otherwise the new bit is dropped, the held bit_out and disagree are kept, and overrun ← 1.
- dis_cnt increments on every H edge with ~uni, including dropped bits. It holds at 2^CNT_W-1.
- Handshake:
  - An edge with bit_valid & bit_ready and no load clears bit_valid.
  - bit_out and disagree hold their value until replaced.
- overrun:
  - ovr_clr=1 clears it.
  - If a set and a clear occur on the same edge, set wins.
- Reset: state = IDLE, phase = 0, s0 = s1 = 0, and every output 0 (bit_out, bit_valid, disagree, dis_cnt, overrun). Reset overrides en and ovr_clr. Reset asserted mid-RUN discards all in-flight state.

## Timing
- All outputs are registered; there are no combinational input→output paths.
- Example with OSR = 16: en rises before edge 0.
  - RUN phase p occupies cycle p+1.
  - Samples are taken at the ends of cycles 8, 9 and 10 (phases 7, 8, 9).
  - bit_valid is high from cycle 11.
- Period: a new voted bit every OSR cycles while en stays high.
- Downstream can sustain full rate with bit_ready tied high. The output is then valid for one cycle per bit period.
- A bit held with ready low loses its successor after OSR cycles, flagged by overrun.

## Structure
- Shared package holds:
  - the FSM state typedef (IDLE, RUN);
  - the default OSR;
  - a function giving the sample-phase constants L/M/H from OSR.
- One natural sub-module: maj3. It is purely combinational, with inputs a/b/c and output y = ab|ac|bc, and it produces vote. Unanimity is computed alongside it.
- The phase counter is $clog2(OSR) bits wide.

## Test plan
- Steady din=1, en=1, ready=1, OSR=16 → bit_out=1, bit_valid pulses one cycle in every 16 (first at cycle 11), disagree=0, dis_cnt=0.
- Inject din=0 only at the phase-8 sample, else 1 → bit_out=1, disagree=1, dis_cnt=1. Repeat with the glitch at phases 7 and 8 → bit_out=0, dis_cnt=2.
- Hold ready=0 across two bit periods → first bit held unchanged, second dropped, overrun=1. Then pulse ovr_clr → overrun=0 on the next cycle.
- Ready asserted on exactly the H edge of the next bit with valid=1 → new bit loaded, bit_valid stays 1, overrun stays 0.
- Drop en at phase 8, then raise it again → no bit produced from the aborted period, phase restarts at 0, the held output is unchanged. Assert rst mid-RUN → all outputs 0 on the next cycle.
- Force 300 non-unanimous votes with CNT_W=8 → dis_cnt saturates at 255.
